// File: rtl/wr_port_rr_arb_mux.sv
// N-to-1 round-robin write-port arbiter/mux feeding a single-write-port register file.
// Optional grant locking is enabled by defining WR_PORT_LOCK_EN.
module wr_port_rr_arb_mux #(
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_wr_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wr_data,
  input  logic [NUM_PORTS-1:0]             port_wr_lock,
  output logic [NUM_PORTS-1:0]             port_grant,
  output logic                             muxed_port_wr_en,
  output logic [ADDR_WIDTH-1:0]            muxed_port_wr_addr,
  output logic [DATA_WIDTH-1:0]            muxed_port_wr_data,
  output logic [15:0]                      conflict_count
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned SUM_WIDTH = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_PORTS - 1);
  localparam logic [SUM_WIDTH-1:0] PORTS_S  = SUM_WIDTH'(NUM_PORTS);

  if (PTR_WIDTH != $clog2(NUM_PORTS)) begin : g_bad_ptr_width
    $error("PTR_WIDTH must equal clog2(NUM_PORTS)");
  end

  logic [PTR_WIDTH-1:0]  r_rr_ptr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [CNT_WIDTH-1:0]  r_conflict_cnt;

  logic [NUM_PORTS-1:0]  w_elig;
  logic                  w_found;
  logic [PTR_WIDTH-1:0]  w_gnt_idx;
  logic [PTR_WIDTH-1:0]  w_next_ptr;
  logic [SUM_WIDTH-1:0]  w_sum;
  logic                  w_multi;

`ifdef WR_PORT_LOCK_EN
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t          r_state;
  logic [PTR_WIDTH-1:0] r_owner;

  // While locked only the owner may win, even if it is idle this cycle.
  always_comb begin
    w_elig = port_wr_en;
    if (r_state == ST_LOCKED) begin
      w_elig = port_wr_en & (NUM_PORTS'(1) << r_owner);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
      r_owner <= '0;
    end else if (w_found) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (port_wr_lock[w_gnt_idx]) begin
            r_state <= ST_LOCKED;
            r_owner <= w_gnt_idx;
          end
        end
        ST_LOCKED: begin
          if (!port_wr_lock[w_gnt_idx]) begin
            r_state <= ST_UNLOCKED;
          end
        end
      endcase
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^port_wr_lock;
  assign w_elig        = port_wr_en;
`endif

  // Scan eligible requesters starting at the round-robin pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + SUM_WIDTH'(k);
      if (w_sum >= PORTS_S) begin
        w_sum = w_sum - PORTS_S;
      end
      if (!w_found && w_elig[w_sum[PTR_WIDTH-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[PTR_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    port_grant = '0;
    if (w_found) begin
      port_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_next_ptr = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + PTR_WIDTH'(1);
  // Two or more requests present: clearing the lowest set bit leaves something behind.
  assign w_multi    = |(port_wr_en & (port_wr_en - NUM_PORTS'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_wr_en <= w_found;
      if (w_found) begin
        r_wr_addr <= port_wr_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wr_data <= port_wr_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        r_rr_ptr  <= w_next_ptr;
      end
      if (w_multi && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign muxed_port_wr_en   = r_wr_en;
  assign muxed_port_wr_addr = r_wr_addr;
  assign muxed_port_wr_data = r_wr_data;
  assign conflict_count     = r_conflict_cnt;

endmodule

// File: tb/tb_wr_port_rr_arb_mux.sv
// Randomised self-checking bench for wr_port_rr_arb_mux against a scan-based reference model.
module tb_wr_port_rr_arb_mux;

  localparam int N  = 8;
  localparam int AW = 6;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      port_wr_en;
  logic [N*AW-1:0]   port_wr_addr;
  logic [N*DW-1:0]   port_wr_data;
  logic [N-1:0]      port_wr_lock;
  logic [N-1:0]      port_grant;
  logic              muxed_port_wr_en;
  logic [AW-1:0]     muxed_port_wr_addr;
  logic [DW-1:0]     muxed_port_wr_data;
  logic [15:0]       conflict_count;

  wr_port_rr_arb_mux #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .port_wr_en         (port_wr_en),
    .port_wr_addr       (port_wr_addr),
    .port_wr_data       (port_wr_data),
    .port_wr_lock       (port_wr_lock),
    .port_grant         (port_grant),
    .muxed_port_wr_en   (muxed_port_wr_en),
    .muxed_port_wr_addr (muxed_port_wr_addr),
    .muxed_port_wr_data (muxed_port_wr_data),
    .conflict_count     (conflict_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt;
  int            m_last_g;

  // Per-port pending request queue (one outstanding request per port)
  bit            pend  [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] pdata [N];
  bit            plock [N];

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (port_wr_en[j] && (!m_locked || j == m_owner)) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant_vec();
    int g;
    logic [N-1:0] v;
    g = model_pick();
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0;
    m_en = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_last_g = -1;
  endtask

  task automatic model_commit();
    int g;
    g = model_pick();
    m_last_g = g;
    if ($countones(port_wr_en) >= 2 && m_cnt < 65535) m_cnt++;
    if (g >= 0) begin
      m_en   = 1'b1;
      m_addr = port_wr_addr[g*AW +: AW];
      m_data = port_wr_data[g*DW +: DW];
`ifdef WR_PORT_LOCK_EN
      if (!m_locked && port_wr_lock[g]) begin
        m_locked = 1'b1;
        m_owner  = g;
      end else if (m_locked && !port_wr_lock[g]) begin
        m_locked = 1'b0;
      end
`endif
      m_ptr = (g + 1) % N;
    end else begin
      m_en = 1'b0;
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; plock[i] = 0;
      paddr[i] = AW'(i); pdata[i] = DW'(i);
    end
  endtask

  task automatic drive_ports();
    for (int i = 0; i < N; i++) begin
      port_wr_en[i]             = pend[i];
      port_wr_lock[i]           = plock[i];
      port_wr_addr[i*AW +: AW]  = paddr[i];
      port_wr_data[i*DW +: DW]  = pdata[i];
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_pend();
    drive_ports();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_pend();
    drive_ports();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (muxed_port_wr_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", muxed_port_wr_en); end
    total++; if (muxed_port_wr_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", muxed_port_wr_addr); end
    total++; if (muxed_port_wr_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", muxed_port_wr_data); end
    total++; if (conflict_count !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", conflict_count); end
    total++; if (port_grant !== '0) begin bad++; $display("FAIL reset_grant got=%b exp=0", port_grant); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    pend[5] = 1; paddr[5] = 6'h2A; pdata[5] = 64'hDEAD_BEEF_0000_0001;
    drive_ports();
    #1;
    total++; if (port_grant !== 8'h20) begin bad++; $display("FAIL single_grant got=%b exp=00100000", port_grant); end
    clock_edge();
    total++; if (muxed_port_wr_en !== 1'b1) begin bad++; $display("FAIL single_en got=%b exp=1", muxed_port_wr_en); end
    total++; if (muxed_port_wr_addr !== 6'h2A) begin bad++; $display("FAIL single_addr got=%h exp=2a", muxed_port_wr_addr); end
    total++; if (muxed_port_wr_data !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL single_data got=%h exp=deadbeef00000001", muxed_port_wr_data); end
    pend[5] = 0;
    @(negedge clk);
    // Pointer probe: every port requesting should pick port 6 next; withdrawn before the edge.
    port_wr_en = '1;
    #1;
    total++; if (port_grant !== 8'h40) begin bad++; $display("FAIL single_ptr_probe got=%b exp=01000000", port_grant); end
    drive_ports();
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 3; c++) begin
      clock_edge();
      total++; if (muxed_port_wr_en !== 1'b0) begin bad++; $display("FAIL idle_en cyc=%0d got=%b exp=0", c, muxed_port_wr_en); end
      total++; if (muxed_port_wr_addr !== 6'h2A || muxed_port_wr_data !== 64'hDEAD_BEEF_0000_0001) begin
        bad++; $display("FAIL idle_hold cyc=%0d got=%h/%h exp=2a/deadbeef00000001", c, muxed_port_wr_addr, muxed_port_wr_data);
      end
    end
    @(negedge clk);
    port_wr_en = '1;
    #1;
    total++; if (port_grant !== 8'h40) begin bad++; $display("FAIL idle_ptr got=%b exp=01000000", port_grant); end
    drive_ports();
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1; paddr[i] = AW'($urandom); pdata[i] = {$urandom, $urandom};
    end
    for (int c = 0; c < N; c++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      drive_ports();
      #1;
      total++; if (port_grant !== (N'(1) << c)) begin bad++; $display("FAIL allports_grant cyc=%0d got=%b exp_idx=%0d", c, port_grant, c); end
      ea = paddr[c]; ed = pdata[c];
      clock_edge();
      total++; if (muxed_port_wr_en !== 1'b1 || muxed_port_wr_addr !== ea || muxed_port_wr_data !== ed) begin
        bad++; $display("FAIL allports_write cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, muxed_port_wr_en, muxed_port_wr_addr, muxed_port_wr_data, ea, ed);
      end
      pend[c] = 0;
    end
    total++; if (conflict_count !== 16'd7) begin bad++; $display("FAIL allports_cnt got=%0d exp=7", conflict_count); end
    @(negedge clk);
    pend[0] = 1; pend[3] = 1;
    drive_ports();
    #1;
    total++; if (port_grant !== 8'h01) begin bad++; $display("FAIL allports_wrap got=%b exp=00000001", port_grant); end
    clear_pend();
    drive_ports();
  endtask

  task automatic test_async_reset();
    do_reset();
    pend[1] = 1; pend[4] = 1; pend[6] = 1;
    for (int i = 0; i < N; i++) begin paddr[i] = AW'($urandom | 1); pdata[i] = {$urandom, $urandom | 1}; end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_ports();
      clock_edge();
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (muxed_port_wr_en !== 1'b0 || muxed_port_wr_addr !== '0 || muxed_port_wr_data !== '0 || conflict_count !== 16'h0) begin
      bad++; $display("FAIL async_reset got=%b/%h/%h/%0d exp=0/0/0/0", muxed_port_wr_en, muxed_port_wr_addr, muxed_port_wr_data, conflict_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (port_grant !== 8'h02) begin bad++; $display("FAIL async_first_grant got=%b exp=00000010", port_grant); end
    clock_edge();
    total++; if (muxed_port_wr_en !== 1'b1 || muxed_port_wr_addr !== paddr[1] || conflict_count !== 16'd1) begin
      bad++; $display("FAIL async_after got=%b/%h/%0d exp=1/%h/1", muxed_port_wr_en, muxed_port_wr_addr, conflict_count, paddr[1]);
    end
    clear_pend();
    drive_ports();
  endtask

  task automatic test_random();
    int waited [N];
    do_reset();
    for (int i = 0; i < N; i++) waited[i] = 0;
    for (int c = 0; c < 500; c++) begin
      logic [N-1:0] eg;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 40)) begin
          pend[i] = 1; paddr[i] = AW'($urandom); pdata[i] = {$urandom, $urandom};
        end
      end
      drive_ports();
      #1;
      eg = model_grant_vec();
      total++; if (port_grant !== eg) begin bad++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, port_grant, eg); end
      clock_edge();
      total++; if (muxed_port_wr_en !== m_en || muxed_port_wr_addr !== m_addr || muxed_port_wr_data !== m_data) begin
        bad++; $display("FAIL rand_write cyc=%0d got=%b/%h/%h exp=%b/%h/%h", c, muxed_port_wr_en, muxed_port_wr_addr, muxed_port_wr_data, m_en, m_addr, m_data);
      end
      total++; if (conflict_count !== 16'(m_cnt)) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, conflict_count, m_cnt); end
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if (i == m_last_g) begin
            total++; if (waited[i] > N - 1) begin bad++; $display("FAIL rand_starve port=%0d waited=%0d limit=%0d", i, waited[i], N - 1); end
            pend[i] = 0; waited[i] = 0;
          end else begin
            waited[i]++;
          end
        end
      end
    end
    clear_pend();
    drive_ports();
  endtask

  task automatic test_lock();
    int exp_seq [6];
    bit p2_done;
`ifdef WR_PORT_LOCK_EN
    exp_seq = '{2, -1, 2, 3, 6, -1};
`else
    exp_seq = '{2, 3, 6, 2, -1, -1};
`endif
    do_reset();
    pend[3] = 1; paddr[3] = 6'h03; pdata[3] = 64'h33;
    pend[6] = 1; paddr[6] = 6'h06; pdata[6] = 64'h66;
    p2_done = 0;
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] eg;
      @(negedge clk);
      if (c == 0) begin pend[2] = 1; plock[2] = 1; paddr[2] = 6'h12; pdata[2] = 64'h2001; end
      else if (c == 1) begin pend[2] = 0; plock[2] = 0; end
      else if (c == 2) begin pend[2] = 1; plock[2] = 0; paddr[2] = 6'h22; pdata[2] = 64'h2002; end
      else if (p2_done) pend[2] = 0;
      drive_ports();
      #1;
      eg = (exp_seq[c] < 0) ? '0 : (N'(1) << exp_seq[c]);
      total++; if (port_grant !== eg) begin bad++; $display("FAIL lock_grant cyc=%0d got=%b exp=%b", c, port_grant, eg); end
      clock_edge();
      total++; if (muxed_port_wr_en !== m_en || muxed_port_wr_addr !== m_addr || muxed_port_wr_data !== m_data) begin
        bad++; $display("FAIL lock_write cyc=%0d got=%b/%h/%h exp=%b/%h/%h", c, muxed_port_wr_en, muxed_port_wr_addr, muxed_port_wr_data, m_en, m_addr, m_data);
      end
      if (m_last_g == 3) pend[3] = 0;
      if (m_last_g == 6) pend[6] = 0;
      if (m_last_g == 2 && c >= 2) p2_done = 1;
      if (m_last_g == 2 && c == 0) pend[2] = 0;
    end
    clear_pend();
    drive_ports();
  endtask

  task automatic test_conflict_saturation();
    do_reset();
    @(negedge clk);
    pend[0] = 1; pend[1] = 1;
    drive_ports();
    repeat (65534) @(posedge clk);
    #1;
    total++; if (conflict_count !== 16'hFFFE) begin bad++; $display("FAIL sat_below got=%h exp=fffe", conflict_count); end
    repeat (7) @(posedge clk);
    #1;
    total++; if (conflict_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", conflict_count); end
    total++; if (muxed_port_wr_en !== 1'b1) begin bad++; $display("FAIL sat_en got=%b exp=1", muxed_port_wr_en); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_idle_hold();
    test_all_ports();
    test_async_reset();
    test_random();
    test_lock();
    test_conflict_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
